bp_fe_mem_sched: RTL and testbench
==================================

Name: bp_fe_mem_sched

Overview:
- Command scheduler in front of the FE memory stage (I-TLB + I-cache pipeline).
- Arbitrates four requesters onto the single mem command port: I-TLB fence, I-TLB fill, I-cache fence and fetch.
- Tracks up to two in-flight fetches and drives the poison input of the memory stage.
- Tags each response with its fetch vaddr, and stalls fetch after a miss until a redirect arrives.

Parameters:
- vaddr_width_p, 39, virtual address width.
- vtag_width_p, 27, virtual tag width for fills.
- tlb_entry_width_p, 40, packed I-TLB entry width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- fetch_vaddr_i  in  vaddr_width_p  fetch PC.
- fetch_v_i  in  1  fetch request.
- fetch_yumi_o  out  1  fetch accepted.
- fill_vtag_i  in  vtag_width_p  fill vtag.
- fill_entry_i  in  tlb_entry_width_p  fill entry.
- fill_v_i  in  1  fill request.
- fill_yumi_o  out  1  fill accepted.
- itlb_fence_v_i  in  1  I-TLB fence request.
- itlb_fence_yumi_o  out  1  I-TLB fence accepted.
- icache_fence_v_i  in  1  I-cache fence request.
- icache_fence_yumi_o  out  1  I-cache fence accepted.
- redirect_v_i  in  1  frontend redirect; squashes in-flight fetches.
- mem_cmd_op_o  out  2  operation: 0 fetch, 1 icache_fence, 2 tlb_fill, 3 tlb_fence.
- mem_cmd_vaddr_o  out  vaddr_width_p  fetch vaddr.
- mem_cmd_vtag_o  out  vtag_width_p  fill vtag.
- mem_cmd_entry_o  out  tlb_entry_width_p  fill entry.
- mem_cmd_v_o  out  1  command valid.
- mem_cmd_yumi_i  in  1  command consumed by the memory stage.
- mem_poison_o  out  1  poison to the memory stage.
- mem_resp_v_i  in  1  memory response valid.
- mem_resp_miss_i  in  1  OR of icache miss, itlb miss, page fault and access fault.
- fetch_resp_v_o  out  1  tagged response valid.
- fetch_resp_vaddr_o  out  vaddr_width_p  vaddr of the responding fetch.
- fetch_resp_miss_o  out  1  response was a miss or fault.
- inflight_o  out  2  count of fetches in the pipeline, 0..2.
- stalled_o  out  1  state is STALL.

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - s1 and s2 invalid, state RUN.
  - All registered outputs 0.
  - All combinational outputs are 0 because nothing is valid.
- Fetch pipeline:
  - A fetch is accepted when mem_cmd_v_o & mem_cmd_yumi_i & op==0.
  - At acceptance the fetch enters s1 (valid + vaddr).
  - On the next cycle s1 moves to s2, unless it was poisoned.
  - The response is expected in the cycle s2 is valid, i.e. accept at t, mem_resp_v_i at t+2.
  - mem_resp_v_i without s2 valid is ignored.
- Poison: mem_poison_o = s1_v & (redirect_v_i | (mem_resp_v_i & s2_v & mem_resp_miss_i)). A poisoned s1 does not advance to s2.
- Response output:
  - fetch_resp_v_o = mem_resp_v_i & s2_v & ~redirect_v_i.
  - vaddr and miss come from s2 and mem_resp_miss_i.
  - s2 clears every cycle unless refilled from s1.
- Redirect:
  - Squashes s1 (via poison) and s2 (response suppressed).
  - Forces STALL→RUN.
  - A fetch accepted in the redirect cycle belongs to the new path: it enters s1 and is not poisoned.
- Issue priority, one command per cycle: itlb_fence > fill > icache_fence > fetch.
  - Non-fetch ops issue only when s1 and s2 are both invalid and no fetch is accepted that cycle.
  - Fetch issues only in RUN with no non-fetch request pending.
- Command payload:
  - mem_cmd_* is driven combinationally from the selected requester.
  - The requester's yumi equals mem_cmd_yumi_i while it is selected.
  - The payload must remain that requester's until yumi.
- States:
  - RUN → DRAIN when a non-fetch request is pending and inflight_o != 0.
  - RUN → STALL on a delivered miss response.
  - DRAIN → RUN when the pipeline is empty, no non-fetch is pending and no miss is outstanding. A miss delivered while in DRAIN goes to STALL.
  - STALL → RUN only on redirect_v_i.
  - In STALL, non-fetch ops may issue (fills needed to resolve TLB misses); fetch may not.
- Simultaneous events:
  - Miss and redirect in the same cycle: redirect wins; response suppressed, state RUN.
  - Reset mid-operation discards all in-flight fetches with no response.
- inflight_o = s1_v + s2_v (2-bit, never exceeds 2).

Test Plan:
- Back-to-back fetches 0x1000, 0x1004, 0x1008 with yumi held high, hits:
  - responses at cycles 2, 3, 4 with vaddrs 0x1000, 0x1004, 0x1008.
  - inflight_o reads 1, 2, 2 during issue.
- Miss response for 0x1000 while 0x1004 is in s1:
  - mem_poison_o=1 that cycle; fetch_resp_miss_o=1 for 0x1000.
  - no response for 0x1004; stalled_o=1.
  - fetch_yumi_o stays 0 until redirect_v_i pulses, then fetch resumes.
- Fill request arriving while two fetches are in flight:
  - state DRAIN; no new fetch accepted.
  - fill issued (op=2) exactly when inflight_o==0.
  - return to RUN the cycle after, with fetch issuing.
- itlb_fence_v_i, fill_v_i, icache_fence_v_i and fetch_v_i all high with an empty pipeline:
  - issue order op 3, 2, 1, 0 on consecutive yumi cycles.
- Redirect in the cycle s2's response arrives, with a new fetch 0x2000 accepted the same cycle:
  - no fetch_resp_v_o; s1 squashed.
  - 0x2000 responds 2 cycles later, unpoisoned.
- reset_n_i low for 1 cycle with inflight_o=2:
  - all outputs 0 next cycle, state RUN.
  - a subsequent mem_resp_v_i is ignored.

Source files
------------

// File: rtl/bp_fe_mem_sched.sv
// bp_fe_mem_sched
//   Command scheduler in front of the FE memory stage (I-TLB + I-cache).
//   Arbitrates I-TLB fence, I-TLB fill, I-cache fence and fetch onto one
//   command port, tracks up to two in-flight fetches (s1, s2), drives the
//   memory-stage poison, tags responses with their fetch vaddr and stalls
//   fetch after a miss until a redirect arrives.
//
// Ports
//   clk_i, reset_n_i                 clock, synchronous active-low reset
//   fetch_* / fill_* / *_fence_*     requester valid/payload in, yumi out
//   redirect_v_i                     frontend redirect, squashes in-flight fetches
//   mem_cmd_*                        selected command to the memory stage
//   mem_poison_o                     kills the fetch currently in s1
//   mem_resp_v_i, mem_resp_miss_i    memory-stage response for s2
//   fetch_resp_*                     tagged response
//   inflight_o, stalled_o            pipeline occupancy, STALL state
module bp_fe_mem_sched #(
   parameter int vaddr_width_p     = 39,
   parameter int vtag_width_p      = 27,
   parameter int tlb_entry_width_p = 40
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [vaddr_width_p-1:0]     fetch_vaddr_i,
   input  logic                         fetch_v_i,
   output logic                         fetch_yumi_o,
   input  logic [vtag_width_p-1:0]      fill_vtag_i,
   input  logic [tlb_entry_width_p-1:0] fill_entry_i,
   input  logic                         fill_v_i,
   output logic                         fill_yumi_o,
   input  logic                         itlb_fence_v_i,
   output logic                         itlb_fence_yumi_o,
   input  logic                         icache_fence_v_i,
   output logic                         icache_fence_yumi_o,
   input  logic                         redirect_v_i,
   output logic [1:0]                   mem_cmd_op_o,
   output logic [vaddr_width_p-1:0]     mem_cmd_vaddr_o,
   output logic [vtag_width_p-1:0]      mem_cmd_vtag_o,
   output logic [tlb_entry_width_p-1:0] mem_cmd_entry_o,
   output logic                         mem_cmd_v_o,
   input  logic                         mem_cmd_yumi_i,
   output logic                         mem_poison_o,
   input  logic                         mem_resp_v_i,
   input  logic                         mem_resp_miss_i,
   output logic                         fetch_resp_v_o,
   output logic [vaddr_width_p-1:0]     fetch_resp_vaddr_o,
   output logic                         fetch_resp_miss_o,
   output logic [1:0]                   inflight_o,
   output logic                         stalled_o
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_STALL} state_e;

   localparam logic [1:0] OP_FETCH = 2'd0;
   localparam logic [1:0] OP_ICF   = 2'd1;
   localparam logic [1:0] OP_FILL  = 2'd2;
   localparam logic [1:0] OP_ITF   = 2'd3;

   state_e                     r_state;
   logic                       r_s1_v, r_s2_v;
   logic [vaddr_width_p-1:0]   r_s1_vaddr, r_s2_vaddr;
   logic                       r_lock_v;
   logic [1:0]                 r_lock_op;

   logic       w_nf_pend, w_pipe_empty, w_resp_hit, w_miss_del, w_poison;
   logic       w_lock_live, w_nf_sel_v, w_fetch_sel_v, w_nf_left;
   logic [1:0] w_nf_op;

   assign w_nf_pend    = itlb_fence_v_i | fill_v_i | icache_fence_v_i;
   assign w_pipe_empty = ~r_s1_v & ~r_s2_v;
   assign w_resp_hit   = mem_resp_v_i & r_s2_v;
   // A miss only counts when the response is actually delivered (redirect wins).
   assign w_miss_del   = w_resp_hit & mem_resp_miss_i & ~redirect_v_i;
   assign w_poison     = r_s1_v & (redirect_v_i | (w_resp_hit & mem_resp_miss_i));

   // A non-fetch command presented without yumi stays selected even if a
   // higher-priority request shows up, so its payload cannot change mid-offer.
   always_comb begin
      w_lock_live = 1'b0;
      case (r_lock_op)
         OP_ITF:  w_lock_live = itlb_fence_v_i;
         OP_FILL: w_lock_live = fill_v_i;
         OP_ICF:  w_lock_live = icache_fence_v_i;
         default: w_lock_live = 1'b0;
      endcase
      w_lock_live = w_lock_live & r_lock_v;
   end

   always_comb begin
      w_nf_op = OP_ICF;
      if (w_lock_live)         w_nf_op = r_lock_op;
      else if (itlb_fence_v_i) w_nf_op = OP_ITF;
      else if (fill_v_i)       w_nf_op = OP_FILL;
   end

   // Non-fetch ops need an empty pipeline; fetch needs RUN and nothing else
   // pending. Fetch is also held off in the cycle a miss is delivered so that
   // nothing new slips into the pipe behind the miss.
   assign w_nf_sel_v    = w_nf_pend & w_pipe_empty;
   assign w_fetch_sel_v = fetch_v_i & (r_state == ST_RUN) & ~w_nf_pend & ~w_miss_del;

   assign mem_cmd_v_o     = w_nf_sel_v | w_fetch_sel_v;
   assign mem_cmd_op_o    = w_nf_sel_v ? w_nf_op : OP_FETCH;
   assign mem_cmd_vaddr_o = w_fetch_sel_v ? fetch_vaddr_i : '0;
   assign mem_cmd_vtag_o  = (w_nf_sel_v && w_nf_op == OP_FILL) ? fill_vtag_i  : '0;
   assign mem_cmd_entry_o = (w_nf_sel_v && w_nf_op == OP_FILL) ? fill_entry_i : '0;

   assign fetch_yumi_o        = w_fetch_sel_v & mem_cmd_yumi_i;
   assign itlb_fence_yumi_o   = w_nf_sel_v & (w_nf_op == OP_ITF)  & mem_cmd_yumi_i;
   assign fill_yumi_o         = w_nf_sel_v & (w_nf_op == OP_FILL) & mem_cmd_yumi_i;
   assign icache_fence_yumi_o = w_nf_sel_v & (w_nf_op == OP_ICF)  & mem_cmd_yumi_i;

   // Non-fetch requests still outstanding after this cycle's issue.
   assign w_nf_left = (itlb_fence_v_i   & ~itlb_fence_yumi_o)
                    | (fill_v_i         & ~fill_yumi_o)
                    | (icache_fence_v_i & ~icache_fence_yumi_o);

   assign mem_poison_o       = w_poison;
   assign fetch_resp_v_o     = w_resp_hit & ~redirect_v_i;
   assign fetch_resp_vaddr_o = fetch_resp_v_o ? r_s2_vaddr : '0;
   assign fetch_resp_miss_o  = fetch_resp_v_o & mem_resp_miss_i;

   assign inflight_o = {1'b0, r_s1_v} + {1'b0, r_s2_v};
   assign stalled_o  = (r_state == ST_STALL);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state    <= ST_RUN;
         r_s1_v     <= 1'b0;
         r_s2_v     <= 1'b0;
         r_s1_vaddr <= '0;
         r_s2_vaddr <= '0;
         r_lock_v   <= 1'b0;
         r_lock_op  <= OP_FETCH;
      end else begin
         r_s1_v <= fetch_yumi_o;
         if (fetch_yumi_o) r_s1_vaddr <= fetch_vaddr_i;
         r_s2_v     <= r_s1_v & ~w_poison;
         r_s2_vaddr <= r_s1_vaddr;
         r_lock_v   <= w_nf_sel_v & ~mem_cmd_yumi_i;
         r_lock_op  <= w_nf_op;
         case (r_state)
            ST_RUN: begin
               if (w_miss_del)                      r_state <= ST_STALL;
               else if (w_nf_pend && !w_pipe_empty) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_miss_del)                      r_state <= ST_STALL;
               else if (w_pipe_empty && !w_nf_left) r_state <= ST_RUN;
            end
            ST_STALL: begin
               if (redirect_v_i) r_state <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_fe_mem_sched.sv
// Bench for bp_fe_mem_sched: directed cycle tables for the documented
// scenarios, then randomized traffic against a queue-based reference model.
module tb_bp_fe_mem_sched;

   localparam int VA = 39;
   localparam int VT = 27;
   localparam int EW = 40;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [VA-1:0] fetch_vaddr;
   logic          fetch_v, fetch_yumi;
   logic [VT-1:0] fill_vtag;
   logic [EW-1:0] fill_entry;
   logic          fill_v, fill_yumi;
   logic          itf_v, itf_yumi, icf_v, icf_yumi;
   logic          redirect_v;
   logic [1:0]    cmd_op;
   logic [VA-1:0] cmd_vaddr;
   logic [VT-1:0] cmd_vtag;
   logic [EW-1:0] cmd_entry;
   logic          cmd_v, cmd_yumi, poison;
   logic          resp_v, resp_miss;
   logic          fresp_v, fresp_miss;
   logic [VA-1:0] fresp_vaddr;
   logic [1:0]    inflight;
   logic          stalled;

   always #5 clk = ~clk;

   bp_fe_mem_sched dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .fetch_vaddr_i(fetch_vaddr), .fetch_v_i(fetch_v), .fetch_yumi_o(fetch_yumi),
      .fill_vtag_i(fill_vtag), .fill_entry_i(fill_entry), .fill_v_i(fill_v), .fill_yumi_o(fill_yumi),
      .itlb_fence_v_i(itf_v), .itlb_fence_yumi_o(itf_yumi),
      .icache_fence_v_i(icf_v), .icache_fence_yumi_o(icf_yumi),
      .redirect_v_i(redirect_v),
      .mem_cmd_op_o(cmd_op), .mem_cmd_vaddr_o(cmd_vaddr), .mem_cmd_vtag_o(cmd_vtag),
      .mem_cmd_entry_o(cmd_entry), .mem_cmd_v_o(cmd_v), .mem_cmd_yumi_i(cmd_yumi),
      .mem_poison_o(poison), .mem_resp_v_i(resp_v), .mem_resp_miss_i(resp_miss),
      .fetch_resp_v_o(fresp_v), .fetch_resp_vaddr_o(fresp_vaddr), .fetch_resp_miss_o(fresp_miss),
      .inflight_o(inflight), .stalled_o(stalled)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // ---------------- directed tables ----------------
   typedef struct {
      logic rst_n, fv; logic [VA-1:0] fa; logic [2:0] nf;  // nf = {itlb_fence, fill, icache_fence}
      logic rd, y, rv, rm;
      logic ecv; logic [1:0] eop; logic [3:0] ey;          // ey = {itf, fill, icf, fetch} yumi
      logic ep, erv; logic [VA-1:0] era; logic erm; logic [1:0] einf; logic est;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic rst_n, fv, input logic [VA-1:0] fa, input logic [2:0] nf,
                               input logic rd, y, rv, rm, ecv, input logic [1:0] eop,
                               input logic [3:0] ey, input logic ep, erv, input logic [VA-1:0] era,
                               input logic erm, input logic [1:0] einf, input logic est);
      vec_t v;
      v.rst_n = rst_n; v.fv = fv; v.fa = fa; v.nf = nf; v.rd = rd; v.y = y; v.rv = rv; v.rm = rm;
      v.ecv = ecv; v.eop = eop; v.ey = ey; v.ep = ep; v.erv = erv; v.era = era; v.erm = erm;
      v.einf = einf; v.est = est;
      tbl.push_back(v);
   endfunction

   function automatic void idle(input logic [1:0] einf, input logic est);
      add(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, einf, est);
   endfunction

   // ---------------- reference model state ----------------
   typedef struct { logic [VA-1:0] va; int age; } ent_t;   // age 0 = just accepted, 1 = response due
   ent_t          pq[$];
   ent_t          nq[$];
   bit            m_wait_redir, m_drain, m_lock_v;
   int            m_lock_op;
   bit            hs1, hs2, deliver, mdel, pois, nf_any, nf_go, f_go, nf_left;
   bit [3:1]      nfv;
   int            sel;
   logic [VA-1:0] s2a;
   logic          e_cv;
   logic [1:0]    e_op;
   logic [3:0]    e_y;
   bit            drop_itf, drop_fill, drop_icf;

   initial begin
      reset_n = 0; fetch_v = 0; fetch_vaddr = '0; fill_v = 0; itf_v = 0; icf_v = 0;
      fill_vtag = VT'(27'h1abcde); fill_entry = EW'(40'h12_3456_789a);
      redirect_v = 0; cmd_yumi = 0; resp_v = 0; resp_miss = 0;
      repeat (2) @(negedge clk);

      // reset state
      add(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
      // back-to-back hits: responses two cycles after each accept
      add(1, 1, 'h1000, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      add(1, 1, 'h1004, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 1, 0);
      add(1, 1, 'h1008, 3'b000, 0, 1, 1, 0, 1, 0, 4'b0001, 0, 1, 'h1000, 0, 2, 0);
      add(1, 0, 0,      3'b000, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 1, 'h1004, 0, 2, 0);
      add(1, 0, 0,      3'b000, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 1, 'h1008, 0, 1, 0);
      idle(0, 0);
      // miss on 0x1000 with 0x1004 in s1: poison, stall until redirect
      add(1, 1, 'h1000, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      add(1, 1, 'h1004, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 1, 0);
      add(1, 1, 'h1008, 3'b000, 0, 1, 1, 1, 0, 0, 4'b0000, 1, 1, 'h1000, 1, 2, 0);
      add(1, 1, 'h1008, 3'b000, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0,       0, 0, 1);
      add(1, 1, 'h1008, 3'b000, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0,       0, 0, 1);
      add(1, 1, 'h1008, 3'b000, 1, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0,       0, 0, 1);
      add(1, 1, 'h1008, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      idle(1, 0);
      add(1, 0, 0,      3'b000, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 'h1008, 0, 1, 0);
      idle(0, 0);
      // fill arrives with two fetches in flight: drain, issue at empty, resume
      add(1, 1, 'h3000, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      add(1, 1, 'h3004, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 1, 0);
      add(1, 1, 'h3008, 3'b010, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 1, 'h3000, 0, 2, 0);
      add(1, 1, 'h3008, 3'b010, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 1, 'h3004, 0, 1, 0);
      add(1, 1, 'h3008, 3'b010, 0, 1, 0, 0, 1, 2, 4'b0100, 0, 0, 0,       0, 0, 0);
      add(1, 1, 'h3008, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      idle(1, 0);
      idle(1, 0);
      // all four requesters high with an empty pipe: 3, 2, 1, 0
      add(1, 1, 'h4000, 3'b111, 0, 1, 0, 0, 1, 3, 4'b1000, 0, 0, 0,       0, 0, 0);
      add(1, 1, 'h4000, 3'b011, 0, 1, 0, 0, 1, 2, 4'b0100, 0, 0, 0,       0, 0, 0);
      add(1, 1, 'h4000, 3'b001, 0, 1, 0, 0, 1, 1, 4'b0010, 0, 0, 0,       0, 0, 0);
      add(1, 1, 'h4000, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      idle(1, 0);
      idle(1, 0);
      // fill offered without yumi keeps its slot when an I-TLB fence arrives
      add(1, 0, 0,      3'b010, 0, 0, 0, 0, 1, 2, 4'b0000, 0, 0, 0,       0, 0, 0);
      add(1, 0, 0,      3'b110, 0, 0, 0, 0, 1, 2, 4'b0000, 0, 0, 0,       0, 0, 0);
      add(1, 0, 0,      3'b110, 0, 1, 0, 0, 1, 2, 4'b0100, 0, 0, 0,       0, 0, 0);
      add(1, 0, 0,      3'b100, 0, 1, 0, 0, 1, 3, 4'b1000, 0, 0, 0,       0, 0, 0);
      // redirect with s2 response and new fetch 0x2000 accepted the same cycle
      add(1, 1, 'h1000, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      add(1, 1, 'h1004, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 1, 0);
      add(1, 1, 'h2000, 3'b000, 1, 1, 1, 0, 1, 0, 4'b0001, 1, 0, 0,       0, 2, 0);
      idle(1, 0);
      add(1, 0, 0,      3'b000, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 'h2000, 0, 1, 0);
      idle(0, 0);
      // miss and redirect together: response suppressed, stays RUN
      add(1, 1, 'h6000, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      idle(1, 0);
      add(1, 0, 0,      3'b000, 1, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0,       0, 1, 0);
      add(1, 1, 'h6004, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      idle(1, 0);
      idle(1, 0);
      // reset with two in flight: all cleared, late response ignored
      add(1, 1, 'h5000, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 0, 0);
      add(1, 1, 'h5004, 3'b000, 0, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0,       0, 1, 0);
      add(0, 0, 0,      3'b000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0,       0, 2, 0);
      add(1, 0, 0,      3'b000, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0,       0, 0, 0);
      add(1, 0, 0,      3'b000, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0,       0, 0, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         reset_n = tbl[i].rst_n; fetch_v = tbl[i].fv; fetch_vaddr = tbl[i].fa;
         {itf_v, fill_v, icf_v} = tbl[i].nf;
         redirect_v = tbl[i].rd; cmd_yumi = tbl[i].y; resp_v = tbl[i].rv; resp_miss = tbl[i].rm;
         #1;
         chk($sformatf("row%0d cmd_v", i), 64'(cmd_v), 64'(tbl[i].ecv));
         if (tbl[i].ecv) chk($sformatf("row%0d cmd_op", i), 64'(cmd_op), 64'(tbl[i].eop));
         chk($sformatf("row%0d yumi", i), 64'({itf_yumi, fill_yumi, icf_yumi, fetch_yumi}), 64'(tbl[i].ey));
         chk($sformatf("row%0d poison", i), 64'(poison), 64'(tbl[i].ep));
         chk($sformatf("row%0d resp_v", i), 64'(fresp_v), 64'(tbl[i].erv));
         if (tbl[i].erv) begin
            chk($sformatf("row%0d resp_vaddr", i), 64'(fresp_vaddr), 64'(tbl[i].era));
            chk($sformatf("row%0d resp_miss", i), 64'(fresp_miss), 64'(tbl[i].erm));
         end
         chk($sformatf("row%0d inflight", i), 64'(inflight), 64'(tbl[i].einf));
         chk($sformatf("row%0d stalled", i), 64'(stalled), 64'(tbl[i].est));
      end

      // ---------------- randomized traffic vs. model ----------------
      itf_v = 0; fill_v = 0; icf_v = 0;
      drop_itf = 0; drop_fill = 0; drop_icf = 0;
      pq.delete(); m_wait_redir = 0; m_drain = 0; m_lock_v = 0; m_lock_op = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         reset_n = !(cyc == 0 || $urandom_range(0, 299) == 0);
         if (drop_itf)  itf_v  = 0;
         if (drop_fill) fill_v = 0;
         if (drop_icf)  icf_v  = 0;
         drop_itf = 0; drop_fill = 0; drop_icf = 0;
         // requesters hold valid until accepted
         if (!itf_v) itf_v = ($urandom_range(0, 15) == 0);
         if (!icf_v) icf_v = ($urandom_range(0, 15) == 0);
         if (!fill_v) begin
            fill_v     = ($urandom_range(0, 11) == 0);
            fill_vtag  = VT'($urandom);
            fill_entry = EW'({$urandom, $urandom});
         end
         fetch_v     = ($urandom_range(0, 3) != 0);
         fetch_vaddr = VA'({$urandom, $urandom});
         redirect_v  = ($urandom_range(0, 11) == 0);
         cmd_yumi    = ($urandom_range(0, 3) != 0);
         hs1 = 0; hs2 = 0; s2a = '0;
         foreach (pq[k]) begin
            if (pq[k].age == 0) hs1 = 1;
            else begin hs2 = 1; s2a = pq[k].va; end
         end
         resp_v    = hs2 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
         resp_miss = ($urandom_range(0, 3) == 0);
         #1;

         nfv = {itf_v, fill_v, icf_v};
         nf_any = |nfv;
         if (m_lock_v && nfv[m_lock_op]) sel = m_lock_op;
         else if (nfv[3]) sel = 3;
         else if (nfv[2]) sel = 2;
         else sel = 1;
         deliver = resp_v && hs2 && !redirect_v;
         mdel    = deliver && resp_miss;
         pois    = hs1 && (redirect_v || (resp_v && hs2 && resp_miss));
         nf_go   = nf_any && (pq.size() == 0);
         f_go    = fetch_v && !m_wait_redir && !m_drain && !nf_any && !mdel;
         e_cv    = nf_go || f_go;
         e_op    = nf_go ? 2'(sel) : 2'd0;
         e_y     = {nf_go && sel == 3 && cmd_yumi, nf_go && sel == 2 && cmd_yumi,
                    nf_go && sel == 1 && cmd_yumi, f_go && cmd_yumi};

         if (reset_n) begin
            chk($sformatf("rnd%0d cmd_v", cyc), 64'(cmd_v), 64'(e_cv));
            if (e_cv) chk($sformatf("rnd%0d cmd_op", cyc), 64'(cmd_op), 64'(e_op));
            if (e_cv && e_op == 0) chk($sformatf("rnd%0d cmd_vaddr", cyc), 64'(cmd_vaddr), 64'(fetch_vaddr));
            if (e_cv && e_op == 2) begin
               chk($sformatf("rnd%0d cmd_vtag", cyc), 64'(cmd_vtag), 64'(fill_vtag));
               chk($sformatf("rnd%0d cmd_entry", cyc), 64'(cmd_entry), 64'(fill_entry));
            end
            chk($sformatf("rnd%0d yumi", cyc), 64'({itf_yumi, fill_yumi, icf_yumi, fetch_yumi}), 64'(e_y));
            chk($sformatf("rnd%0d poison", cyc), 64'(poison), 64'(pois));
            chk($sformatf("rnd%0d resp_v", cyc), 64'(fresp_v), 64'(deliver));
            if (deliver) begin
               chk($sformatf("rnd%0d resp_vaddr", cyc), 64'(fresp_vaddr), 64'(s2a));
               chk($sformatf("rnd%0d resp_miss", cyc), 64'(fresp_miss), 64'(resp_miss));
            end
            chk($sformatf("rnd%0d inflight", cyc), 64'(inflight), 64'(pq.size()));
            chk($sformatf("rnd%0d stalled", cyc), 64'(stalled), 64'(m_wait_redir));
         end

         if (!reset_n) begin
            pq.delete(); m_wait_redir = 0; m_drain = 0; m_lock_v = 0;
         end else begin
            nf_left = (nfv[3] && !e_y[3]) || (nfv[2] && !e_y[2]) || (nfv[1] && !e_y[1]);
            if (m_wait_redir) begin
               if (redirect_v) m_wait_redir = 0;
            end else if (m_drain) begin
               if (mdel) begin m_wait_redir = 1; m_drain = 0; end
               else if (pq.size() == 0 && !nf_left) m_drain = 0;
            end else begin
               if (mdel) m_wait_redir = 1;
               else if (nf_any && pq.size() != 0) m_drain = 1;
            end
            nq.delete();
            foreach (pq[k]) if (pq[k].age == 0 && !pois) nq.push_back('{pq[k].va, 1});
            if (e_y[0]) nq.push_back('{fetch_vaddr, 0});
            pq = nq;
            m_lock_v  = e_cv && e_op != 0 && !cmd_yumi;
            m_lock_op = int'(e_op);
            drop_itf  = e_y[3];
            drop_fill = e_y[2];
            drop_icf  = e_y[1];
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
